// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST engine: sequencer states, march element codes
// and per-element attributes (direction, read/write data polarity, read-only flag).
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ONLY,
    S_RD,
    S_WR,
    S_RD_ONLY,
    S_DRAIN,
    S_NEXT_BANK,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5
  } elem_t;

  // Ascending address order; M3 and M4 run downward.
  function automatic logic elem_up(input elem_t e);
    return !(e == M3 || e == M4);
  endfunction

  // Read half expects all-ones.
  function automatic logic elem_rd_one(input elem_t e);
    return (e == M2 || e == M4);
  endfunction

  // Write half stores all-ones.
  function automatic logic elem_wr_one(input elem_t e);
    return (e == M1 || e == M3);
  endfunction

  function automatic logic elem_rd_only(input elem_t e);
    return (e == M5);
  endfunction

  function automatic elem_t elem_next(input elem_t e);
    elem_t n;
    case (e)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = M0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data checker: registers each issued read, compares it against MEM_ODATA the
// following cycle, filters repeat reports of the same word and counts emitted records.
module mbist_cmp
  import mbist_pkg::*;
#(
  parameter int SEL_W  = 6,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              rd_valid,
  input  logic [SEL_W-1:0]  rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pass,
  output logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  cnt
);

  logic              chk_valid;
  logic [SEL_W-1:0]  chk_bank;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic              last_valid;
  logic [SEL_W-1:0]  last_bank;
  logic [ADDR_W-1:0] last_addr;
  logic              mismatch;
  logic              dup;
  logic              emit;

  always_comb begin
    mismatch = chk_valid && (rd_data != chk_exp);
    dup      = last_valid && (last_bank == chk_bank) && (last_addr == chk_addr);
    emit     = mismatch && !dup;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid  <= 1'b0;
      chk_bank   <= '0;
      chk_addr   <= '0;
      chk_exp    <= '0;
      last_valid <= 1'b0;
      last_bank  <= '0;
      last_addr  <= '0;
      pass       <= 1'b0;
      sel        <= '0;
      addr       <= '0;
      cnt        <= '0;
    end else begin
      pass <= 1'b0;
      if (clear) begin
        chk_valid  <= 1'b0;
        last_valid <= 1'b0;
        cnt        <= '0;
      end else begin
        chk_valid <= rd_valid;
        chk_bank  <= rd_bank;
        chk_addr  <= rd_addr;
        chk_exp   <= rd_exp;
        if (emit) begin
          pass       <= 1'b1;
          sel        <= chk_bank;
          addr       <= chk_addr;
          last_valid <= 1'b1;
          last_bank  <= chk_bank;
          last_addr  <= chk_addr;
          // Saturate but keep emitting records.
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march.sv
// March C- BIST sequencer: walks every bank through M0..M5, drives the SRAM ports
// from registers and hands read tags to mbist_cmp for checking.
module mbist_march
  import mbist_pkg::*;
#(
  parameter int NUM_BANKS = 64,
  parameter int SEL_W     = 6,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 12
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  output logic [NUM_BANKS-1:0] MEM_CSB,
  output logic                 MEM_WEB,
  output logic                 MEM_OEB,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  output logic [DATA_W-1:0]    MEM_IDATA,
  input  logic [DATA_W-1:0]    MEM_ODATA,
  output logic                 BIST_EN,
  output logic                 BIST_PASS,
  output logic [SEL_W-1:0]     NEED_REPAIR_SELECT,
  output logic [ADDR_W-1:0]    NEED_REPAIR_ADDR,
  output logic                 BIST_DONE,
  output logic [CNT_W-1:0]     FAULT_CNT
);

  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
  localparam logic [SEL_W-1:0]  BANK_LAST = SEL_W'(NUM_BANKS - 1);

  state_t            state, nxt_state;
  elem_t             elem, nxt_elem;
  logic [SEL_W-1:0]  bank, nxt_bank;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic              accept;
  logic              at_end;
  logic [ADDR_W-1:0] step_addr;
  logic              cmd_wr, cmd_rd;

  logic              iss_rd;
  logic [SEL_W-1:0]  iss_bank;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_exp;

  function automatic logic [ADDR_W-1:0] start_addr(input elem_t e);
    return elem_up(e) ? '0 : ADDR_TOP;
  endfunction

  always_comb begin
    accept    = START && (state == S_IDLE || state == S_DONE);
    at_end    = elem_up(elem) ? (addr == ADDR_TOP) : (addr == '0);
    step_addr = elem_up(elem) ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
  end

  always_comb begin
    nxt_state = state;
    nxt_elem  = elem;
    nxt_bank  = bank;
    nxt_addr  = addr;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          nxt_state = S_WR_ONLY;
          nxt_elem  = M0;
          nxt_bank  = '0;
          nxt_addr  = '0;
        end
      end
      S_WR_ONLY: begin
        if (at_end) begin
          nxt_state = S_RD;
          nxt_elem  = M1;
          nxt_addr  = start_addr(M1);
        end else begin
          nxt_addr = step_addr;
        end
      end
      S_RD: nxt_state = S_WR;
      S_WR: begin
        // Element turn loads the next element's start address directly, so
        // the up->down and down->up boundaries cost no extra cycle.
        if (at_end) begin
          nxt_elem  = elem_next(elem);
          nxt_addr  = start_addr(elem_next(elem));
          nxt_state = elem_rd_only(elem_next(elem)) ? S_RD_ONLY : S_RD;
        end else begin
          nxt_state = S_RD;
          nxt_addr  = step_addr;
        end
      end
      S_RD_ONLY: begin
        if (at_end) nxt_state = S_DRAIN;
        else        nxt_addr  = step_addr;
      end
      S_DRAIN: nxt_state = S_NEXT_BANK;
      S_NEXT_BANK: begin
        if (bank == BANK_LAST) begin
          nxt_state = S_DONE;
        end else begin
          nxt_state = S_WR_ONLY;
          nxt_elem  = M0;
          nxt_bank  = bank + SEL_W'(1);
          nxt_addr  = '0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_wr = (nxt_state == S_WR_ONLY) || (nxt_state == S_WR);
    cmd_rd = (nxt_state == S_RD) || (nxt_state == S_RD_ONLY);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_IDLE;
      elem  <= M0;
      bank  <= '0;
      addr  <= '0;
    end else begin
      state <= nxt_state;
      elem  <= nxt_elem;
      bank  <= nxt_bank;
      addr  <= nxt_addr;
    end
  end

  // Port registers load the command of the state being entered, so an access is
  // on the pins during the very cycle its state is active.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MEM_CSB   <= '1;
      MEM_WEB   <= 1'b1;
      MEM_OEB   <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_IDATA <= '0;
      BIST_EN   <= 1'b0;
      BIST_DONE <= 1'b0;
      iss_rd    <= 1'b0;
      iss_bank  <= '0;
      iss_addr  <= '0;
      iss_exp   <= '0;
    end else begin
      MEM_CSB   <= (cmd_wr || cmd_rd) ? ~(NUM_BANKS'(1) << nxt_bank) : '1;
      MEM_WEB   <= !cmd_wr;
      MEM_OEB   <= !cmd_rd;
      MEM_ADDR  <= (cmd_wr || cmd_rd) ? nxt_addr : '0;
      MEM_IDATA <= cmd_wr ? {DATA_W{elem_wr_one(nxt_elem)}} : '0;
      BIST_EN   <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      BIST_DONE <= (nxt_state == S_DONE);
      iss_rd    <= cmd_rd;
      iss_bank  <= nxt_bank;
      iss_addr  <= nxt_addr;
      iss_exp   <= {DATA_W{elem_rd_one(nxt_elem)}};
    end
  end

  mbist_cmp #(
    .SEL_W  (SEL_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_cmp (
    .clk      (CLK),
    .rst_n    (RSTN),
    .clear    (accept),
    .rd_valid (iss_rd),
    .rd_bank  (iss_bank),
    .rd_addr  (iss_addr),
    .rd_exp   (iss_exp),
    .rd_data  (MEM_ODATA),
    .pass     (BIST_PASS),
    .sel      (NEED_REPAIR_SELECT),
    .addr     (NEED_REPAIR_ADDR),
    .cnt      (FAULT_CNT)
  );

endmodule

// File: tb/tb_mbist_march.sv
// Bench for mbist_march: 2 banks x 8 words behavioural SRAM with injectable faults,
// a march reference model filling a record scoreboard, and directed run scenarios.
module tb_mbist_march;

  localparam int NB = 2;
  localparam int SW = 1;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int NW = 8;
  localparam int RUN_LEN = NB * (10 * NW + 2);

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          START;
  logic [NB-1:0] MEM_CSB;
  logic          MEM_WEB, MEM_OEB;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_IDATA;
  logic [DW-1:0] MEM_ODATA = '0;
  logic          BIST_EN, BIST_PASS, BIST_DONE;
  logic [SW-1:0] NEED_REPAIR_SELECT;
  logic [AW-1:0] NEED_REPAIR_ADDR;
  logic [CW-1:0] FAULT_CNT;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sram    [NB][NW];
  logic [DW-1:0] ref_mem [NB][NW];
  logic [DW-1:0] sa0     [NB][NW];
  logic [DW-1:0] sa1     [NB][NW];
  bit            coup_en;
  int            exp_q[$];
  int            n_pushed;
  int            ref_lv, ref_lb, ref_la;

  mbist_march #(
    .NUM_BANKS (NB),
    .SEL_W     (SW),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .CLK                (CLK),
    .RSTN               (RSTN),
    .START              (START),
    .MEM_CSB            (MEM_CSB),
    .MEM_WEB            (MEM_WEB),
    .MEM_OEB            (MEM_OEB),
    .MEM_ADDR           (MEM_ADDR),
    .MEM_IDATA          (MEM_IDATA),
    .MEM_ODATA          (MEM_ODATA),
    .BIST_EN            (BIST_EN),
    .BIST_PASS          (BIST_PASS),
    .NEED_REPAIR_SELECT (NEED_REPAIR_SELECT),
    .NEED_REPAIR_ADDR   (NEED_REPAIR_ADDR),
    .BIST_DONE          (BIST_DONE),
    .FAULT_CNT          (FAULT_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] fault_rd(input int b, input int a, input logic [DW-1:0] v);
    return (v & ~sa0[b][a]) | sa1[b][a];
  endfunction

  // Synchronous SRAM: read data appears the cycle after the read is issued.
  always @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (MEM_CSB[b] === 1'b0) begin
        if (MEM_WEB === 1'b0) begin
          sram[b][MEM_ADDR] <= MEM_IDATA;
          if (coup_en && b == 0 && MEM_ADDR == 3'd2) sram[0][3] <= ~sram[0][3];
        end
        if (MEM_OEB === 1'b0) MEM_ODATA <= fault_rd(b, int'(MEM_ADDR), sram[b][MEM_ADDR]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTN === 1'b1 && BIST_PASS === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 32'(BIST_PASS), 32'd0);
      end else begin
        int p;
        p = exp_q.pop_front();
        chk("rec_select", 32'(NEED_REPAIR_SELECT), 32'(p / NW));
        chk("rec_addr", 32'(NEED_REPAIR_ADDR), 32'(p % NW));
      end
    end
  end

  task automatic ref_wr(input int b, input int a, input logic [DW-1:0] v);
    ref_mem[b][a] = v;
    if (coup_en && b == 0 && a == 2) ref_mem[0][3] = ~ref_mem[0][3];
  endtask

  task automatic ref_rd(input int b, input int a, input logic [DW-1:0] e);
    if (fault_rd(b, a, ref_mem[b][a]) !== e) begin
      if (!(ref_lv == 1 && ref_lb == b && ref_la == a)) begin
        exp_q.push_back(b * NW + a);
        n_pushed++;
        ref_lv = 1; ref_lb = b; ref_la = a;
      end
    end
  endtask

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0).
  task automatic ref_run();
    logic [DW-1:0] rv;
    int a;
    exp_q.delete();
    n_pushed = 0;
    ref_lv = 0; ref_lb = 0; ref_la = 0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) ref_mem[b][w] = sram[b][w];
    for (int b = 0; b < NB; b++) begin
      for (int w = 0; w < NW; w++) ref_wr(b, w, 8'h00);
      for (int e = 1; e <= 4; e++) begin
        rv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        for (int i = 0; i < NW; i++) begin
          a = (e <= 2) ? i : NW - 1 - i;
          ref_rd(b, a, rv);
          ref_wr(b, a, ~rv);
        end
      end
      for (int w = 0; w < NW; w++) ref_rd(b, w, 8'h00);
    end
  endtask

  task automatic clear_faults();
    coup_en = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) begin
        sa0[b][w] = '0;
        sa1[b][w] = '0;
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csb"},   32'(MEM_CSB), 32'(2'b11));
    chk({tag, "_web"},   32'(MEM_WEB), 32'd1);
    chk({tag, "_oeb"},   32'(MEM_OEB), 32'd1);
    chk({tag, "_addr"},  32'(MEM_ADDR), 32'd0);
    chk({tag, "_idata"}, 32'(MEM_IDATA), 32'd0);
    chk({tag, "_en"},    32'(BIST_EN), 32'd0);
    chk({tag, "_pass"},  32'(BIST_PASS), 32'd0);
    chk({tag, "_done"},  32'(BIST_DONE), 32'd0);
    chk({tag, "_cnt"},   32'(FAULT_CNT), 32'd0);
    chk({tag, "_sel"},   32'(NEED_REPAIR_SELECT), 32'd0);
    chk({tag, "_raddr"}, 32'(NEED_REPAIR_ADDR), 32'd0);
  endtask

  // Pulses START, then counts cycles until BIST_DONE (bounded). Optional START
  // glitch and reset abort at given cycle numbers (-1 disables).
  task automatic run_march(input int glitch_at, input int reset_at, output int cycles);
    int  n;
    bit  fin;
    n = 0;
    fin = 0;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    chk("first_csb", 32'(MEM_CSB), 32'(2'b10));
    chk("first_web", 32'(MEM_WEB), 32'd0);
    chk("first_en", 32'(BIST_EN), 32'd1);
    chk("first_done", 32'(BIST_DONE), 32'd0);
    while (!fin && n < 4 * RUN_LEN) begin
      @(negedge CLK);
      if (n == glitch_at) START = 1'b1;
      if (n == reset_at) begin
        RSTN = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge CLK);
        chk_reset_outputs("abort_hold");
        RSTN = 1'b1;
        fin = 1;
      end else begin
        @(posedge CLK);
        #1;
        START = 1'b0;
        n++;
        if (BIST_DONE === 1'b1) fin = 1;
      end
    end
    cycles = n;
  endtask

  task automatic full_run(input string tag, input int glitch_at);
    int cyc;
    int exp_cnt;
    ref_run();
    exp_cnt = (n_pushed > 3) ? 3 : n_pushed;
    run_march(glitch_at, -1, cyc);
    repeat (2) @(negedge CLK);
    chk({tag, "_cycles"}, 32'(cyc), 32'(RUN_LEN));
    chk({tag, "_done"}, 32'(BIST_DONE), 32'd1);
    chk({tag, "_en_off"}, 32'(BIST_EN), 32'd0);
    chk({tag, "_fault_cnt"}, 32'(FAULT_CNT), 32'(exp_cnt));
    chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    RSTN  = 1'b0;
    START = 1'b0;
    clear_faults();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++) sram[b][w] = 8'($urandom);
    repeat (3) @(negedge CLK);
    chk_reset_outputs("por");
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    full_run("clean", -1);

    clear_faults();
    sa0[1][5] = 8'h08;
    full_run("sa0_b1a5", -1);

    clear_faults();
    sa1[0][0] = 8'h01;
    sa1[0][7] = 8'h01;
    full_run("sa1_b0", -1);

    clear_faults();
    coup_en = 1'b1;
    full_run("coupling", -1);

    clear_faults();
    exp_q.delete();
    run_march(-1, 40, cyc);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge CLK);

    full_run("post_abort", -1);
    full_run("start_glitch", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
